// File: rtl/apb_arbiter.sv
// apb_arbiter: two-port round-robin arbiter and APB transfer sequencer.
// Two requesters (m0, m1) hand over single read/write transactions on a
// valid/ready handshake. The winner's transaction is run through the APB
// SETUP and ACCESS phases, and a one-cycle response carrying read data and
// error status is returned to that requester only.
//
// Optional feature: define APB_ARB_TIMEOUT_EN to enable an ACCESS-phase
// watchdog. After TIMEOUT wait-state cycles without PREADY the transfer is
// aborted and reported to the owner with rsp_err=1. Without the macro the
// ACCESS phase waits indefinitely for PREADY.

module apb_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              rst,

   input  logic              m0_valid,
   output logic              m0_ready,
   input  logic              m0_write,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_rsp_valid,
   output logic [DATA_W-1:0] m0_rsp_rdata,
   output logic              m0_rsp_err,

   input  logic              m1_valid,
   output logic              m1_ready,
   input  logic              m1_write,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_rsp_valid,
   output logic [DATA_W-1:0] m1_rsp_rdata,
   output logic              m1_rsp_err,

   output logic              PSEL,
   output logic              PENABLE,
   output logic              PWRITE,
   output logic [ADDR_W-1:0] PADDR,
   output logic [DATA_W-1:0] PWDATA,
   input  logic [DATA_W-1:0] PRDATA,
   input  logic              PREADY,
   input  logic              PSLVERR
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic                last_grant_q, last_grant_d;
   logic                owner_q, owner_d;
   logic                write_q, write_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;

   logic                m0_rsp_valid_q, m0_rsp_valid_d;
   logic                m1_rsp_valid_q, m1_rsp_valid_d;
   logic [DATA_W-1:0]   m0_rsp_rdata_q, m0_rsp_rdata_d;
   logic [DATA_W-1:0]   m1_rsp_rdata_q, m1_rsp_rdata_d;
   logic                m0_rsp_err_q, m0_rsp_err_d;
   logic                m1_rsp_err_q, m1_rsp_err_d;

   logic                grant0;
   logic                grant1;
   logic                timeout_hit;

`ifdef APB_ARB_TIMEOUT_EN
   localparam logic [8:0] TIMEOUT_LIM = 9'(TIMEOUT);

   logic [7:0]          to_cnt_q, to_cnt_d;

   // Watchdog counter: cleared while in SETUP so it starts at 0 on entering
   // ACCESS, then counts every ACCESS cycle that ends without PREADY.
   always_comb begin
      to_cnt_d = to_cnt_q;
      if (state_q == SETUP) begin
         to_cnt_d = 8'd0;
      end else if (state_q == ACCESS && !PREADY) begin
         to_cnt_d = to_cnt_q + 8'd1;
      end
   end

   // Abort fires on the edge where this wait cycle would bring the count to
   // TIMEOUT; a PREADY on that same edge takes priority as a normal finish.
   always_comb begin
      timeout_hit = (state_q == ACCESS) && !PREADY &&
                    (({1'b0, to_cnt_q} + 9'd1) >= TIMEOUT_LIM);
   end

   // Watchdog counter register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         to_cnt_q <= 8'd0;
      end else begin
         to_cnt_q <= to_cnt_d;
      end
   end
`else
   logic unused_timeout_cfg;

   assign unused_timeout_cfg = (TIMEOUT != 0);

   // Without the watchdog an ACCESS phase only ends on PREADY.
   always_comb begin
      timeout_hit = 1'b0;
   end
`endif

   // Round-robin arbitration, only meaningful in IDLE: a lone request wins,
   // a tie goes to whoever was not granted last. Held low during reset so
   // every output reads 0 while rst is asserted.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         if (m0_valid && m1_valid) begin
            if (last_grant_q) begin
               grant0 = 1'b1;
            end else begin
               grant1 = 1'b1;
            end
         end else begin
            grant0 = m0_valid;
            grant1 = m1_valid;
         end
      end
   end

   // Next-state logic: accept a request in IDLE, one SETUP cycle, then ACCESS
   // until PREADY (or the watchdog) finishes the transfer and queues the
   // owner's one-cycle response.
   always_comb begin
      state_d        = state_q;
      last_grant_d   = last_grant_q;
      owner_d        = owner_q;
      write_d        = write_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      m0_rsp_valid_d = 1'b0;
      m1_rsp_valid_d = 1'b0;
      m0_rsp_rdata_d = '0;
      m1_rsp_rdata_d = '0;
      m0_rsp_err_d   = 1'b0;
      m1_rsp_err_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (grant0 || grant1) begin
               owner_d      = grant1;
               last_grant_d = grant1;
               write_d      = grant1 ? m1_write : m0_write;
               addr_d       = grant1 ? m1_addr  : m0_addr;
               wdata_d      = grant1 ? m1_wdata : m0_wdata;
               state_d      = SETUP;
            end
         end

         SETUP: begin
            state_d = ACCESS;
         end

         ACCESS: begin
            if (PREADY) begin
               state_d = IDLE;
               if (owner_q) begin
                  m1_rsp_valid_d = 1'b1;
                  m1_rsp_err_d   = PSLVERR;
                  if (!write_q && !PSLVERR) begin
                     m1_rsp_rdata_d = PRDATA;
                  end
               end else begin
                  m0_rsp_valid_d = 1'b1;
                  m0_rsp_err_d   = PSLVERR;
                  if (!write_q && !PSLVERR) begin
                     m0_rsp_rdata_d = PRDATA;
                  end
               end
            end else if (timeout_hit) begin
               state_d = IDLE;
               if (owner_q) begin
                  m1_rsp_valid_d = 1'b1;
                  m1_rsp_err_d   = 1'b1;
               end else begin
                  m0_rsp_valid_d = 1'b1;
                  m0_rsp_err_d   = 1'b1;
               end
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State, latched transaction and response registers; reset clears every
   // output and makes m0 the winner of the first tie.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         last_grant_q   <= 1'b1;
         owner_q        <= 1'b0;
         write_q        <= 1'b0;
         addr_q         <= '0;
         wdata_q        <= '0;
         m0_rsp_valid_q <= 1'b0;
         m1_rsp_valid_q <= 1'b0;
         m0_rsp_rdata_q <= '0;
         m1_rsp_rdata_q <= '0;
         m0_rsp_err_q   <= 1'b0;
         m1_rsp_err_q   <= 1'b0;
      end else begin
         state_q        <= state_d;
         last_grant_q   <= last_grant_d;
         owner_q        <= owner_d;
         write_q        <= write_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         m0_rsp_valid_q <= m0_rsp_valid_d;
         m1_rsp_valid_q <= m1_rsp_valid_d;
         m0_rsp_rdata_q <= m0_rsp_rdata_d;
         m1_rsp_rdata_q <= m1_rsp_rdata_d;
         m0_rsp_err_q   <= m0_rsp_err_d;
         m1_rsp_err_q   <= m1_rsp_err_d;
      end
   end

   // APB control follows the phase directly; the payload comes from the
   // latched transaction and therefore holds its last value in IDLE.
   always_comb begin
      PSEL    = (state_q != IDLE);
      PENABLE = (state_q == ACCESS);
      PWRITE  = write_q;
      PADDR   = addr_q;
      PWDATA  = wdata_q;
   end

   // Requester-side handshake and response outputs.
   always_comb begin
      m0_ready     = grant0;
      m1_ready     = grant1;
      m0_rsp_valid = m0_rsp_valid_q;
      m1_rsp_valid = m1_rsp_valid_q;
      m0_rsp_rdata = m0_rsp_rdata_q;
      m1_rsp_rdata = m1_rsp_rdata_q;
      m0_rsp_err   = m0_rsp_err_q;
      m1_rsp_err   = m1_rsp_err_q;
   end

endmodule

// File: tb/tb_apb_arbiter.sv
// tb_apb_arbiter: directed and randomized checks of apb_arbiter.
// Expected behaviour comes from a transaction-level model of the arbiter:
// the model remembers who won last, predicts each winner, and derives the
// APB phase sequence and response contents from the request it issued.
// With APB_ARB_TIMEOUT_EN defined the watchdog abort and its boundary are
// exercised as well.

`timescale 1ns/1ps

module tb_apb_arbiter;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              rst;

   logic              m0_valid, m0_ready, m0_write;
   logic [ADDR_W-1:0] m0_addr;
   logic [DATA_W-1:0] m0_wdata;
   logic              m0_rsp_valid;
   logic [DATA_W-1:0] m0_rsp_rdata;
   logic              m0_rsp_err;

   logic              m1_valid, m1_ready, m1_write;
   logic [ADDR_W-1:0] m1_addr;
   logic [DATA_W-1:0] m1_wdata;
   logic              m1_rsp_valid;
   logic [DATA_W-1:0] m1_rsp_rdata;
   logic              m1_rsp_err;

   logic              PSEL, PENABLE, PWRITE;
   logic [ADDR_W-1:0] PADDR;
   logic [DATA_W-1:0] PWDATA;
   logic [DATA_W-1:0] PRDATA;
   logic              PREADY, PSLVERR;

   logic              reqValid [2];
   logic              reqWrite [2];
   logic [ADDR_W-1:0] reqAddr  [2];
   logic [DATA_W-1:0] reqWdata [2];

   int                vectors     = 0;
   int                miscompares = 0;
   logic              modelLast;

   assign m0_valid = reqValid[0];
   assign m0_write = reqWrite[0];
   assign m0_addr  = reqAddr[0];
   assign m0_wdata = reqWdata[0];
   assign m1_valid = reqValid[1];
   assign m1_write = reqWrite[1];
   assign m1_addr  = reqAddr[1];
   assign m1_wdata = reqWdata[1];

   // Free-running 10 ns clock.
   always #5 clk = ~clk;

   apb_arbiter #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m0_valid     (m0_valid),
      .m0_ready     (m0_ready),
      .m0_write     (m0_write),
      .m0_addr      (m0_addr),
      .m0_wdata     (m0_wdata),
      .m0_rsp_valid (m0_rsp_valid),
      .m0_rsp_rdata (m0_rsp_rdata),
      .m0_rsp_err   (m0_rsp_err),
      .m1_valid     (m1_valid),
      .m1_ready     (m1_ready),
      .m1_write     (m1_write),
      .m1_addr      (m1_addr),
      .m1_wdata     (m1_wdata),
      .m1_rsp_valid (m1_rsp_valid),
      .m1_rsp_rdata (m1_rsp_rdata),
      .m1_rsp_err   (m1_rsp_err),
      .PSEL         (PSEL),
      .PENABLE      (PENABLE),
      .PWRITE       (PWRITE),
      .PADDR        (PADDR),
      .PWDATA       (PWDATA),
      .PRDATA       (PRDATA),
      .PREADY       (PREADY),
      .PSLVERR      (PSLVERR)
   );

   // Per-requester views of the DUT outputs, indexed by requester number.
   function automatic logic readyOf(input logic n);
      return n ? m1_ready : m0_ready;
   endfunction

   function automatic logic rspValidOf(input logic n);
      return n ? m1_rsp_valid : m0_rsp_valid;
   endfunction

   function automatic logic [DATA_W-1:0] rspRdataOf(input logic n);
      return n ? m1_rsp_rdata : m0_rsp_rdata;
   endfunction

   function automatic logic rspErrOf(input logic n);
      return n ? m1_rsp_err : m0_rsp_err;
   endfunction

   // Compare a 32-bit observed value with the model's expectation.
   task automatic checkOutput(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Compare a single-bit observed value with the model's expectation.
   task automatic checkBit(input string tag, input logic obs, input logic exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Run one complete transfer starting from an IDLE cycle: present the
   // requests, predict the winner from the round-robin rule, walk the APB
   // phases with the requested number of wait states and check the response.
   // Returns in the response cycle, where the next request may be accepted.
   task automatic applyStimulus(input logic v0, input logic v1, input int waits,
                                input logic [DATA_W-1:0] rdata,
                                input logic slverr);
      logic              win;
      logic              expWrite;
      logic [ADDR_W-1:0] expAddr;
      logic [DATA_W-1:0] expWdata;
      logic [DATA_W-1:0] expRdata;

      if (v0 && v1) begin
         win = (modelLast == 1'b1) ? 1'b0 : 1'b1;
      end else begin
         win = v1;
      end
      expWrite = reqWrite[win];
      expAddr  = reqAddr[win];
      expWdata = reqWdata[win];
      expRdata = (expWrite || slverr) ? '0 : rdata;

      reqValid[0] = v0;
      reqValid[1] = v1;
      #1;
      checkBit("ready_winner", readyOf(win), 1'b1);
      checkBit("ready_loser", readyOf(~win), 1'b0);

      @(posedge clk);
      modelLast = win;
      #1;
      reqValid[win] = 1'b0;
      reqWrite[win] = 1'($urandom);
      reqAddr[win]  = $urandom;
      reqWdata[win] = $urandom;

      checkBit("setup_psel", PSEL, 1'b1);
      checkBit("setup_penable", PENABLE, 1'b0);
      checkBit("setup_pwrite", PWRITE, expWrite);
      checkOutput("setup_paddr", PADDR, expAddr);
      checkOutput("setup_pwdata", PWDATA, expWdata);
      checkBit("setup_no_ready", m0_ready | m1_ready, 1'b0);
      checkBit("setup_no_rsp", m0_rsp_valid | m1_rsp_valid, 1'b0);

      @(posedge clk);
      #1;
      for (int w = 0; w <= waits; w++) begin
         checkBit("access_psel", PSEL, 1'b1);
         checkBit("access_penable", PENABLE, 1'b1);
         checkOutput("access_paddr", PADDR, expAddr);
         checkOutput("access_pwdata", PWDATA, expWdata);
         checkBit("access_no_rsp", m0_rsp_valid | m1_rsp_valid, 1'b0);
         if (w < waits) begin
            PREADY  = 1'b0;
            PRDATA  = $urandom;
            PSLVERR = 1'($urandom);
         end else begin
            PREADY  = 1'b1;
            PRDATA  = rdata;
            PSLVERR = slverr;
         end
         @(posedge clk);
         #1;
      end
      PREADY  = 1'b0;
      PRDATA  = $urandom;
      PSLVERR = 1'($urandom);

      checkBit("rsp_valid_owner", rspValidOf(win), 1'b1);
      checkOutput("rsp_rdata_owner", rspRdataOf(win), expRdata);
      checkBit("rsp_err_owner", rspErrOf(win), slverr);
      checkBit("rsp_valid_other", rspValidOf(~win), 1'b0);
      checkOutput("rsp_rdata_other", rspRdataOf(~win), '0);
      checkBit("rsp_err_other", rspErrOf(~win), 1'b0);
      checkBit("idle_psel", PSEL, 1'b0);
      checkBit("idle_penable", PENABLE, 1'b0);
      checkOutput("idle_paddr_hold", PADDR, expAddr);
   endtask

   // Directed scenarios first, then a randomized mix, then the summary.
   initial begin
      rst         = 1'b1;
      reqValid[0] = 1'b1;
      reqValid[1] = 1'b1;
      reqWrite[0] = 1'b0;
      reqWrite[1] = 1'b0;
      reqAddr[0]  = '0;
      reqAddr[1]  = '0;
      reqWdata[0] = '0;
      reqWdata[1] = '0;
      PRDATA      = '0;
      PREADY      = 1'b0;
      PSLVERR     = 1'b0;
      modelLast   = 1'b1;

      #3;
      checkBit("reset_psel", PSEL, 1'b0);
      checkBit("reset_penable", PENABLE, 1'b0);
      checkBit("reset_pwrite", PWRITE, 1'b0);
      checkOutput("reset_paddr", PADDR, '0);
      checkOutput("reset_pwdata", PWDATA, '0);
      checkBit("reset_ready", m0_ready | m1_ready, 1'b0);
      checkBit("reset_rsp_valid", m0_rsp_valid | m1_rsp_valid, 1'b0);
      checkOutput("reset_rsp_rdata", m0_rsp_rdata | m1_rsp_rdata, '0);
      reqValid[0] = 1'b0;
      reqValid[1] = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      rst = 1'b0;
      @(posedge clk);
      #1;

      $display("[TB] m0 write, zero wait states");
      reqWrite[0] = 1'b1;
      reqAddr[0]  = 32'h0000_0010;
      reqWdata[0] = 32'hDEAD_BEEF;
      applyStimulus(1'b1, 1'b0, 0, 32'h0, 1'b0);

      $display("[TB] m1 read, two wait states");
      reqWrite[1] = 1'b0;
      reqAddr[1]  = 32'h0000_0004;
      applyStimulus(1'b0, 1'b1, 2, 32'h1234_5678, 1'b0);

      $display("[TB] both requesters contending for four transfers");
      for (int i = 0; i < 4; i++) begin
         applyStimulus(1'b1, 1'b1, 0, $urandom, 1'b0);
      end

      $display("[TB] write completing with PSLVERR");
      reqWrite[0] = 1'b1;
      applyStimulus(1'b1, 1'b0, 0, $urandom, 1'b1);

      $display("[TB] reset during ACCESS of a read");
      reqWrite[0] = 1'b0;
      reqAddr[0]  = $urandom;
      reqValid[0] = 1'b1;
      #1;
      @(posedge clk);
      #1;
      reqValid[0] = 1'b0;
      @(posedge clk);
      #1;
      checkBit("rst_pre_access", PENABLE, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkBit("rst_psel_drop", PSEL, 1'b0);
      checkBit("rst_penable_drop", PENABLE, 1'b0);
      checkOutput("rst_paddr_clear", PADDR, '0);
      PREADY = 1'b1;
      PRDATA = $urandom;
      @(posedge clk);
      #2;
      rst       = 1'b0;
      modelLast = 1'b1;
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         checkBit("rst_no_rsp", m0_rsp_valid | m1_rsp_valid, 1'b0);
         checkBit("rst_stay_idle", PSEL, 1'b0);
      end
      PREADY = 1'b0;
      applyStimulus(1'b0, 1'b1, 0, $urandom, 1'b0);

`ifdef APB_ARB_TIMEOUT_EN
      $display("[TB] watchdog abort with PREADY held low");
      reqWrite[0] = 1'b0;
      reqValid[0] = 1'b1;
      #1;
      @(posedge clk);
      modelLast = 1'b0;
      #1;
      reqValid[0] = 1'b0;
      @(posedge clk);
      #1;
      PREADY = 1'b0;
      PRDATA = $urandom;
      for (int c = 0; c < TIMEOUT; c++) begin
         checkBit("to_access_held", PENABLE, 1'b1);
         @(posedge clk);
         #1;
      end
      checkBit("to_psel_drop", PSEL, 1'b0);
      checkBit("to_rsp_valid", m0_rsp_valid, 1'b1);
      checkBit("to_rsp_err", m0_rsp_err, 1'b1);
      checkOutput("to_rsp_rdata", m0_rsp_rdata, '0);

      $display("[TB] PREADY arriving on the abort edge");
      reqWrite[1] = 1'b0;
      applyStimulus(1'b0, 1'b1, TIMEOUT - 1, 32'hA5A5_5A5A, 1'b0);
`endif

      $display("[TB] randomized transfers");
      for (int i = 0; i < 24; i++) begin
         logic [1:0] pick;
         pick = 2'($urandom_range(1, 3));
         applyStimulus(pick[0], pick[1], $urandom_range(0, 3), $urandom,
                       ($urandom_range(0, 3) == 0));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
